// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port served by data_mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ack, p0_err, p0_rdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ack, p0_err, p0_rdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer for the data port of the unified memory.
// One access at a time: IDLE -> ACCESS -> RESP, or IDLE -> RESP for out-of-range addresses.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 3072
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic              cur;
    logic              last_gnt;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic              p0_ack_q, p1_ack_q;
    logic              p0_err_q, p1_err_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

    logic              gnt_any;
    logic              gnt;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              gnt_oor;

    // On a tie the port that was not served last wins.
    always_comb begin
        gnt_any = bus.p0_req | bus.p1_req;
        gnt     = (bus.p0_req & bus.p1_req) ? ~last_gnt : bus.p1_req;
        gnt_we    = gnt ? bus.p1_we    : bus.p0_we;
        gnt_addr  = gnt ? bus.p1_addr  : bus.p0_addr;
        gnt_wdata = gnt ? bus.p1_wdata : bus.p0_wdata;
        gnt_oor   = 32'(gnt_addr) >= DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= 1'b0;
            last_gnt    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        cur <= gnt;
                        if (gnt_oor) begin
                            // Rejected access: acknowledge with error, memory untouched.
                            p0_ack_q <= ~gnt;
                            p1_ack_q <= gnt;
                            p0_err_q <= ~gnt;
                            p1_err_q <= gnt;
                            state    <= RESP;
                        end else begin
                            mem_addr_q  <= gnt_addr;
                            mem_wdata_q <= gnt_wdata;
                            mem_re_q    <= ~gnt_we;
                            mem_we_q    <= gnt_we;
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_re_q) begin
                        if (cur) p1_rdata_q <= bus.mem_rdata;
                        else     p0_rdata_q <= bus.mem_rdata;
                    end
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    p0_ack_q <= ~cur;
                    p1_ack_q <= cur;
                    p0_err_q <= 1'b0;
                    p1_err_q <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    p0_err_q <= 1'b0;
                    p1_err_q <= 1'b0;
                    last_gnt <= cur;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.p0_ack    = p0_ack_q;
    assign bus.p1_ack    = p1_ack_q;
    assign bus.p0_err    = p0_err_q;
    assign bus.p1_err    = p1_err_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule
